// File: rtl/namuru_pkg.sv
// Shared types and constants for the Namuru dump arbiter: FSM states,
// accumulator field layout within a record, and parameter defaults.
package namuru_pkg;

  localparam int NCH_DEF    = 4;
  localparam int ACC_W_DEF  = 16;
  localparam int ACC_FIELDS = 6;
  localparam int TS_W       = 24;

  // Field index within a record; index 0 sits at the LSBs, i_early at the MSBs.
  localparam int FLD_Q_LATE   = 0;
  localparam int FLD_I_LATE   = 1;
  localparam int FLD_Q_PROMPT = 2;
  localparam int FLD_I_PROMPT = 3;
  localparam int FLD_Q_EARLY  = 4;
  localparam int FLD_I_EARLY  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int field_lsb(input int fld, input int acc_w);
    return fld * acc_w;
  endfunction

endpackage

// File: rtl/namuru_rr_pick.sv
// Combinational round-robin picker: the first set request found searching
// upward from last+1, wrapping from NCH-1 back to 0.
module namuru_rr_pick #(
  parameter int NCH   = 4,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] grant,
  output logic             any
);

  logic [SEL_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant = '0;
    w_idx = '0;
    any   = |req;
    // Walk from the farthest candidate to the nearest so the nearest hit is assigned last and wins.
    for (int i = NCH; i >= 1; i--) begin
      w_idx = SEL_W'((int'(last) + i) % NCH);
      if (req[w_idx]) grant = w_idx;
    end
  end

endmodule

// File: rtl/namuru_dump_arb.sv
// Serialises per-channel accumulator dumps into a valid/ready record stream.
// Optional capture timestamp enabled by defining NAMURU_DUMP_TIMESTAMP_EN.
module namuru_dump_arb
  import namuru_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NCH-1:0]              dump_i,
  output logic [SEL_W-1:0]            ch_sel_o,
  input  logic [ACC_FIELDS*ACC_W-1:0] acc_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [SEL_W-1:0]            out_ch_o,
  output logic [ACC_FIELDS*ACC_W-1:0] out_data_o,
  output logic [TS_W-1:0]             out_ts_o,
  output logic [NCH-1:0]              overrun_o,
  input  logic [NCH-1:0]              overrun_clr_i,
  output logic                        irq_o
);

  state_e           r_state;
  logic [NCH-1:0]   r_pending;
  logic [SEL_W-1:0] r_last;

  logic [SEL_W-1:0] w_grant;
  logic             w_any;
  logic [NCH-1:0]   w_clr;
  logic [NCH-1:0]   w_ovr_set;

  namuru_rr_pick #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (r_pending),
    .last  (r_last),
    .grant (w_grant),
    .any   (w_any)
  );

  // The channel being captured this cycle releases its pending bit.
  always_comb begin
    w_clr = '0;
    if (r_state == ST_SEL) w_clr[ch_sel_o] = 1'b1;
  end

  // A dump landing on the releasing edge is a fresh request, not a miss.
  assign w_ovr_set = dump_i & r_pending & ~w_clr;

  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_last      <= SEL_W'(NCH - 1);
      overrun_o   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      ch_sel_o    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | dump_i;
      overrun_o <= (overrun_o & ~overrun_clr_i) | w_ovr_set;

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            ch_sel_o <= w_grant;
            r_last   <= w_grant;
            r_state  <= ST_SEL;
          end
        end
        ST_SEL: begin
          out_data_o  <= acc_i;
          out_ch_o    <= ch_sel_o;
          out_valid_o <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef NAMURU_DUMP_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ts_cnt <= '0;
      out_ts_o <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (r_state == ST_SEL) out_ts_o <= r_ts_cnt;
    end
  end
`else
  assign out_ts_o = '0;
`endif

  assign irq_o = out_valid_o | (|overrun_o);

endmodule

// File: tb/tb_namuru_dump_arb.sv
// Directed bench for namuru_dump_arb: a cycle table for the basic flow and
// overrun handling, then hand sequences for reset, fairness, collision and timestamps.
module tb_namuru_dump_arb;
  import namuru_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  dump_i;
  logic [1:0]  ch_sel_o;
  logic [95:0] acc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  out_ch_o;
  logic [95:0] out_data_o;
  logic [23:0] out_ts_o;
  logic [3:0]  overrun_o;
  logic [3:0]  overrun_clr_i;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  logic [95:0] acc_tbl [4];

  namuru_dump_arb #(.NCH(4), .ACC_W(16)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .dump_i        (dump_i),
    .ch_sel_o      (ch_sel_o),
    .acc_i         (acc_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_ch_o      (out_ch_o),
    .out_data_o    (out_data_o),
    .out_ts_o      (out_ts_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i),
    .irq_o         (irq_o)
  );

  always #5 sys_clk = ~sys_clk;

  // External channel mux driven by the arbiter's select.
  always_comb acc_i = acc_tbl[ch_sel_o];

  typedef struct {
    logic [3:0] dump;
    logic       ready;
    logic [3:0] clr;
    logic       e_valid;
    logic [1:0] e_ch;
    logic [1:0] e_sel;
    logic [3:0] e_ovr;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_record(input logic [1:0] ch, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (out_valid_o) seen = 1'b1;
    end
    check({name, " seen"}, 128'(seen), 128'(1'b1));
    if (seen) begin
      check({name, " ch"}, 128'(out_ch_o), 128'(ch));
      check({name, " data"}, 128'(out_data_o), 128'(acc_tbl[ch]));
      check({name, " ovr"}, 128'(overrun_o), 128'(4'b0));
    end
  endtask

  initial begin
    logic [23:0] ts1;
    logic [23:0] ts2;

    acc_tbl[0] = 96'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5;
    acc_tbl[1] = 96'h1111_2222_3333_4444_5555_6666;
    acc_tbl[2] = 96'hC0DE_C1DE_C2DE_C3DE_C4DE_C5DE;
    acc_tbl[3] = 96'hF00D_F11D_F22D_F33D_F44D_F55D;

    //            dump     rdy   clr      val   ch     sel    ovr
    vecs[0]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000};
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 2'd1, 4'b0000};
    vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b0000};
    vecs[4]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000};
    vecs[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0000};
    vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0000};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0000};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0000};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0000};
    vecs[11] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0100};
    vecs[12] = '{4'b0000, 1'b0, 4'b0100, 1'b1, 2'd0, 2'd0, 4'b0000};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd2, 4'b0000};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 2'd2, 4'b0000};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd2, 4'b0000};

    sys_rst       = 1'b1;
    dump_i        = '0;
    out_ready_i   = 1'b0;
    overrun_clr_i = '0;
    repeat (2) tick();
    sys_rst = 1'b0;

    check("rst valid", 128'(out_valid_o), 128'(1'b0));
    check("rst sel",   128'(ch_sel_o),    128'(2'd0));
    check("rst ch",    128'(out_ch_o),    128'(2'd0));
    check("rst data",  128'(out_data_o),  128'(96'd0));
    check("rst ts",    128'(out_ts_o),    128'(24'd0));
    check("rst ovr",   128'(overrun_o),   128'(4'b0));
    check("rst irq",   128'(irq_o),       128'(1'b0));

    for (int k = 0; k < 17; k++) begin
      dump_i        = vecs[k].dump;
      out_ready_i   = vecs[k].ready;
      overrun_clr_i = vecs[k].clr;
      tick();
      check($sformatf("v%0d valid", k), 128'(out_valid_o), 128'(vecs[k].e_valid));
      check($sformatf("v%0d sel", k),   128'(ch_sel_o),    128'(vecs[k].e_sel));
      check($sformatf("v%0d ovr", k),   128'(overrun_o),   128'(vecs[k].e_ovr));
      check($sformatf("v%0d irq", k),   128'(irq_o),
            128'(vecs[k].e_valid | (|vecs[k].e_ovr)));
      if (vecs[k].e_valid) begin
        check($sformatf("v%0d ch", k),   128'(out_ch_o),   128'(vecs[k].e_ch));
        check($sformatf("v%0d data", k), 128'(out_data_o), 128'(acc_tbl[vecs[k].e_ch]));
`ifndef NAMURU_DUMP_TIMESTAMP_EN
        check($sformatf("v%0d ts", k),   128'(out_ts_o),   128'(24'd0));
`endif
      end
      if (k == 2)
        check("v2 i_prompt", 128'(out_data_o[field_lsb(FLD_I_PROMPT, 16) +: 16]), 128'(16'h3333));
    end
    dump_i        = '0;
    overrun_clr_i = '0;

    // Reset while a record is held and another dump is pending.
    out_ready_i = 1'b0;
    dump_i = 4'b0100;
    tick();
    dump_i = '0;
    tick();
    tick();
    check("hold valid", 128'(out_valid_o), 128'(1'b1));
    check("hold ch",    128'(out_ch_o),    128'(2'd2));
    dump_i = 4'b0001;
    tick();
    sys_rst = 1'b1;
    dump_i  = 4'b1000;
    tick();
    sys_rst = 1'b0;
    dump_i  = '0;
    check("mrst valid", 128'(out_valid_o), 128'(1'b0));
    check("mrst ch",    128'(out_ch_o),    128'(2'd0));
    check("mrst data",  128'(out_data_o),  128'(96'd0));
    check("mrst sel",   128'(ch_sel_o),    128'(2'd0));
    check("mrst ts",    128'(out_ts_o),    128'(24'd0));
    check("mrst ovr",   128'(overrun_o),   128'(4'b0));
    check("mrst irq",   128'(irq_o),       128'(1'b0));
    repeat (5) tick();
    check("post rst idle valid", 128'(out_valid_o), 128'(1'b0));
    check("post rst idle sel",   128'(ch_sel_o),    128'(2'd0));

    // Fairness: all four at once come out 0,1,2,3 after reset.
    out_ready_i = 1'b1;
    dump_i = 4'b1111;
    tick();
    dump_i = '0;
    wait_record(2'd0, "fair0");
    wait_record(2'd1, "fair1");
    wait_record(2'd2, "fair2");
    wait_record(2'd3, "fair3");
    repeat (3) tick();
    check("fair idle valid", 128'(out_valid_o), 128'(1'b0));

    // Collision: a ch0 dump on its own capture edge yields a second record.
    dump_i = 4'b0001;
    tick();
    dump_i = '0;
    tick();
    check("coll sel", 128'(ch_sel_o), 128'(2'd0));
    dump_i = 4'b0001;
    tick();
    dump_i = '0;
    check("coll first valid", 128'(out_valid_o), 128'(1'b1));
    check("coll first ch",    128'(out_ch_o),    128'(2'd0));
    check("coll ovr",         128'(overrun_o),   128'(4'b0));
    wait_record(2'd0, "coll second");
    repeat (3) tick();
    check("coll drained", 128'(out_valid_o), 128'(1'b0));

    // Two captures exactly 100 cycles apart.
    dump_i = 4'b0010;
    tick();
    dump_i = '0;
    tick();
    tick();
    check("ts1 valid", 128'(out_valid_o), 128'(1'b1));
    ts1 = out_ts_o;
    repeat (97) tick();
    dump_i = 4'b0010;
    tick();
    dump_i = '0;
    tick();
    tick();
    check("ts2 valid", 128'(out_valid_o), 128'(1'b1));
    ts2 = out_ts_o;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    check("ts delta", 128'(ts2 - ts1), 128'(24'd100));
`else
    check("ts1 zero", 128'(ts1), 128'(24'd0));
    check("ts2 zero", 128'(ts2), 128'(24'd0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/namuru_dump_arb.md
NAMURU_DUMP_ARB -- requirements
Module: namuru_dump_arb

Interface
REQ-001 Parameter NCH, default 4: number of tracking channels served (2..16).
REQ-002 Parameter ACC_W, default 16: width of each accumulator word.
REQ-003 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 dump_i  in  NCH  per-channel dump pulse, one cycle wide, already in the sys_clk domain.
REQ-006 ch_sel_o  out  clog2(NCH)  selects which channel drives acc_i through an external mux.
REQ-007 acc_i  in  6*ACC_W  selected channel's {i_early, q_early, i_prompt, q_prompt, i_late, q_late}, with i_early at the MSBs.
REQ-008 out_valid_o  out  1  captured record available.
REQ-009 out_ready_i  in  1  consumer accepts the record.
REQ-010 out_ch_o  out  clog2(NCH)  channel index of the record.
REQ-011 out_data_o  out  6*ACC_W  captured accumulators.
REQ-012 out_ts_o  out  24  capture timestamp; see Configuration.
REQ-013 overrun_o  out  NCH  sticky missed-dump flags.
REQ-014 overrun_clr_i  in  NCH  one-cycle clear strobes for overrun_o.
REQ-015 irq_o  out  1  interrupt; equals out_valid_o OR (|overrun_o).

Function
REQ-016 pending[NCH] SHALL set on the edge sampling dump_i[n]=1.
REQ-017 The FSM SHALL use three states: IDLE, SEL and HOLD.
REQ-018 IDLE -> SEL when pending is nonzero; the round-robin winner is loaded into ch_sel_o on that edge.
REQ-019 SEL -> HOLD unconditionally; that edge SHALL capture acc_i into out_data_o and ch_sel_o into out_ch_o, clear pending[winner] and set out_valid_o.
REQ-020 HOLD -> IDLE on the edge where out_valid_o & out_ready_i; out_valid_o clears on that edge.
REQ-021 out_ready_i SHALL be ignored outside HOLD.
REQ-022 Latency: with the FSM in IDLE, dump_i high in cycle 0 SHALL give ch_sel_o valid in cycle 2 and out_valid_o high in cycle 3.
REQ-023 Round-robin search SHALL start at last_grant+1 and wrap from NCH-1 to 0; last_grant updates on the IDLE->SEL edge.
REQ-024 dump_i[n] while pending[n] is already 1 SHALL set overrun_o[n], and pending[n] stays 1.
REQ-025 dump_i[n] on the same SEL edge that clears pending[n] SHALL leave pending[n]=1 with no overrun, because the new dump wins.
REQ-026 Simultaneous overrun set and overrun_clr_i[n] SHALL leave overrun_o[n]=1.
REQ-027 out_data_o, out_ch_o and out_ts_o SHALL stay stable while out_valid_o=1.
REQ-028 Dumps arriving in any state SHALL be recorded in pending and never dropped, except where counted as overrun per REQ-024.

Reset
REQ-029 sys_rst SHALL force state=IDLE, pending=0, overrun_o=0, out_valid_o=0, out_data_o=0, out_ch_o=0, out_ts_o=0, ch_sel_o=0 and last_grant=NCH-1, so channel 0 wins first.
REQ-030 Reset asserted in SEL or HOLD SHALL discard the in-flight record with no ack required; dump_i sampled during reset SHALL be ignored.

Configuration
REQ-031 Macro NAMURU_DUMP_TIMESTAMP_EN defined: a free-running 24-bit counter is cleared by reset, increments every cycle and wraps 0xFFFFFF -> 0; its value is latched into out_ts_o on the SEL->HOLD edge.
REQ-032 Macro not defined: no counter is built and out_ts_o is tied to 0.

Structure
REQ-033 Package namuru_pkg SHALL hold the FSM state enum, the accumulator field offsets within acc_i, and the NCH/ACC_W defaults.
REQ-034 Sub-module namuru_rr_pick SHALL be a combinational round-robin picker with inputs req[NCH] and last[clog2 NCH] and outputs grant index and any.

Verification
REQ-035 Single dump: dump_i=4'b0010 in cycle 0, acc_i=96'h1111_2222_3333_4444_5555_6666, ready=1 -> out_valid_o in cycle 3, out_ch_o=1, out_data_o equals acc_i.
REQ-036 Fairness: dump_i=4'b1111 in one cycle, ready=1 -> records emitted for channels 0,1,2,3 in order, no overrun.
REQ-037 Overrun: out_ready_i=0, two dump_i[2] pulses 5 cycles apart -> overrun_o=4'b0100 and irq_o=1; overrun_clr_i[2] -> overrun_o=0.
REQ-038 Collision: dump_i[0] on the SEL edge for ch0 -> a second ch0 record follows and overrun_o[0]=0.
REQ-039 Reset mid-HOLD: sys_rst for 1 cycle with out_valid_o=1 -> all outputs 0 next cycle; a later dump_i[3] is granted before ch0-2 pending dumps only per the reset order (ch0 first).
REQ-040 With NAMURU_DUMP_TIMESTAMP_EN: two captures 100 cycles apart -> out_ts_o values differ by 100; without the macro, out_ts_o=0.
